radix_conv_scheduler: RTL and testbench
=======================================

// Module: radix_conv_scheduler
// PURPOSE
//  Shares one radix converter (half/single/double -> double) between two burst requesters.
//  Grants whole bursts round-robin and sets the converter mode (cv_ctrl) per burst.
//  Changes cv_ctrl only when the converter pipeline is empty, and tags every result with its source.
//  Sits between the SpMV value/vector fetch paths and the converter, ahead of the SpMV kernel.
// PARAMETERS
//  MAX_INFLIGHT  16  credit cap on converter occupancy; also depth of the result-tag FIFO
//  PURGE_CYC     32  post-reset cycles spent draining stale converter results (must be >= IP latency)
// PORTS
//  clk           in   1   clock (single domain)
//  rst           in   1   synchronous reset, active-high
//  reqN_valid    in   1   N=0,1: requester beat valid
//  reqN_ready    out  1   requester beat accepted
//  reqN_data     in   64  raw operand (half in [15:0], single in [31:0], double in [63:0])
//  reqN_last     in   1   last beat of burst
//  reqN_mode     in   2   0=half, 1=single, 2=double passthrough, 3=illegal; sampled at grant only
//  cv_ctrl       out  2   converter mode select
//  cv_in_valid   out  1   converter input valid
//  cv_in_ready   in   1   converter input ready
//  cv_in_data    out  64  converter input data
//  cv_out_valid  in   1   converter result valid
//  cv_out_ready  out  1   converter result ready
//  cv_out_data   in   64  converter result (double)
//  res_valid     out  1   result to kernel valid
//  res_ready     in   1   kernel ready
//  res_data      out  64  = cv_out_data
//  res_src       out  1   requester that issued this result
//  res_last      out  1   result is last of its burst
//  err_mode      out  1   sticky: a burst with mode 3 was dropped; cleared only by rst
// BEHAVIOUR
//  Reset: state=PURGE, cv_ctrl=0, all valids/readies=0, res_src=0, res_last=0, err_mode=0,
//    rr pointer=req0, inflight=0, tag FIFO empty. Converter IP is not reset and may hold stale data.
//  PURGE: cv_ctrl=0 (drains both IP stages), cv_out_ready=1, results discarded, res_valid=0,
//    reqN_ready=0. After PURGE_CYC cycles -> IDLE.
//  IDLE: arbitrate among reqN_valid; requester at rr pointer wins ties. Latch winner (gnt) and its mode (gmode).
//    gmode=3 -> DROP. gmode==cv_ctrl or inflight==0 -> cv_ctrl<=gmode, STREAM.
//    Otherwise -> DRAIN. Grant is decided in IDLE; no beat is accepted in the IDLE cycle.
//  DRAIN: no new issue; results keep flowing. When inflight==0: cv_ctrl<=gmode, -> STREAM.
//  STREAM: cv_in_valid = req[gnt]_valid & inflight<MAX_INFLIGHT & !tagfifo_full.
//    req[gnt]_ready = cv_in_ready under the same gate; other requester's ready=0.
//    cv_in_data = req[gnt]_data. Each issue pushes {gnt,last} to the tag FIFO.
//    Issue with last=1 -> IDLE, rr pointer <= ~gnt. reqN_mode is ignored mid-burst.
//  DROP: req[gnt]_ready=1; beats are discarded, err_mode<=1. On the last beat -> IDLE, rr pointer <= ~gnt.
//  Result path (all states except PURGE): res_valid=cv_out_valid, cv_out_ready=res_ready, res_data=cv_out_data.
//    Each result fire pops the tag FIFO.
//    Tag FIFO empty on a result fire (mode-2 same-cycle passthrough): res_src=gnt, res_last=req[gnt]_last,
//    and the tag is neither pushed nor popped.
//  inflight: +1 on issue, -1 on result fire, unchanged if both occur in the same cycle.
//    Never exceeds MAX_INFLIGHT; never underflows.
//  Invariant: cv_ctrl changes only in PURGE exit / IDLE / DRAIN with inflight==0. It never changes in STREAM.
//  Same-mode back-to-back bursts from different requesters overlap without draining; the tag FIFO keeps src correct.
//  rst mid-burst: all state is abandoned and PURGE re-entered. Partially issued bursts are lost (upstream must also reset).
// TESTING
//  1. rst, converter preloaded with 3 stale results -> 0 res_valid during PURGE, 3 cv_out fires discarded, then IDLE.
//  2. req0 mode0, 4 beats 16'h3C00 -> cv_ctrl=0; 4 results 64'h3FF0000000000000, res_src=0, res_last on 4th only.
//  3. req0 mode1 burst, then req1 mode0 pending -> no req1 issue until inflight==0; cv_ctrl 1->0 while pipeline is empty.
//  4. Both valid, same mode 2, continuous -> grants alternate 0,1,0,1; no DRAIN; res_src follows issue order.
//  5. res_ready=0 held -> inflight stops at 16, cv_in_valid=0; release -> all 16 results delivered in order.
//  6. req1 mode3 burst of 3 -> 3 beats consumed, none reach converter, err_mode=1 sticky; next req0 burst proceeds normally.

Source files
------------

// File: rtl/radix_conv_scheduler_if.sv
// Signal bundle around radix_conv_scheduler: two burst requesters, converter in/out and result stream.
// master = scheduler side, slave = requesters/converter/kernel side.
interface radix_conv_scheduler_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [63:0] req0_data;
  logic        req0_last;
  logic [1:0]  req0_mode;
  logic        req1_valid;
  logic        req1_ready;
  logic [63:0] req1_data;
  logic        req1_last;
  logic [1:0]  req1_mode;
  logic [1:0]  cv_ctrl;
  logic        cv_in_valid;
  logic        cv_in_ready;
  logic [63:0] cv_in_data;
  logic        cv_out_valid;
  logic        cv_out_ready;
  logic [63:0] cv_out_data;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        res_src;
  logic        res_last;
  logic        err_mode;

  modport master (
    input  req0_valid, req0_data, req0_last, req0_mode,
    input  req1_valid, req1_data, req1_last, req1_mode,
    output req0_ready, req1_ready,
    output cv_ctrl, cv_in_valid, cv_in_data,
    input  cv_in_ready,
    input  cv_out_valid, cv_out_data,
    output cv_out_ready,
    output res_valid, res_data, res_src, res_last,
    input  res_ready,
    output err_mode
  );

  modport slave (
    output req0_valid, req0_data, req0_last, req0_mode,
    output req1_valid, req1_data, req1_last, req1_mode,
    input  req0_ready, req1_ready,
    input  cv_ctrl, cv_in_valid, cv_in_data,
    output cv_in_ready,
    output cv_out_valid, cv_out_data,
    input  cv_out_ready,
    input  res_valid, res_data, res_src, res_last,
    output res_ready,
    output err_mode
  );
endinterface

// File: rtl/radix_conv_scheduler.sv
// Round-robin burst scheduler sharing one radix converter between two requesters; switches converter
// mode only with an empty pipeline and tags each result with its source and last flag.
module radix_conv_scheduler #(
  parameter int MAX_INFLIGHT = 16,
  parameter int PURGE_CYC    = 32
) (
  input logic                   clk,
  input logic                   rst,
  radix_conv_scheduler_if.master bus
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int KW = $clog2(PURGE_CYC + 1);

  typedef enum logic [2:0] {S_PURGE, S_IDLE, S_DRAIN, S_STREAM, S_DROP} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   purge_cnt_q, purge_cnt_d;
  logic [1:0]      cv_ctrl_q, cv_ctrl_d;
  logic [1:0]      gmode_q, gmode_d;
  logic            gnt_q, gnt_d;
  logic            rr_q, rr_d;
  logic            err_q, err_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   tag_cnt_q, tag_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]      tag_q [MAX_INFLIGHT];

  logic       sel_vld, sel_last, win, win_mode_ok;
  logic [1:0] win_mode;
  logic       gate, issue, res_fire, tag_empty, tag_full, tag_push, tag_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + PW'(1);
  endfunction

  assign sel_vld        = gnt_q ? bus.req1_valid : bus.req0_valid;
  assign sel_last       = gnt_q ? bus.req1_last  : bus.req0_last;
  assign bus.cv_in_data = gnt_q ? bus.req1_data  : bus.req0_data;

  // Pointer requester keeps the grant whenever it is valid; otherwise the other one takes it.
  assign win         = (rr_q ? bus.req1_valid : bus.req0_valid) ? rr_q : ~rr_q;
  assign win_mode    = win ? bus.req1_mode : bus.req0_mode;
  assign win_mode_ok = (win_mode == cv_ctrl_q) || (inflight_q == '0);

  assign tag_empty = (tag_cnt_q == '0);
  assign tag_full  = (tag_cnt_q == CW'(MAX_INFLIGHT));
  assign gate      = (inflight_q < CW'(MAX_INFLIGHT)) && !tag_full;
  assign issue     = bus.cv_in_valid && bus.cv_in_ready;
  assign res_fire  = (state_q != S_PURGE) && bus.cv_out_valid && bus.res_ready;
  // A result that passes straight through with no tag queued is labelled from the live grant instead.
  assign tag_pop   = res_fire && !tag_empty;
  assign tag_push  = issue && !(res_fire && tag_empty);

  assign bus.cv_ctrl  = cv_ctrl_q;
  assign bus.err_mode = err_q;

  always_comb begin
    state_d         = state_q;
    purge_cnt_d     = purge_cnt_q;
    cv_ctrl_d       = cv_ctrl_q;
    gmode_d         = gmode_q;
    gnt_d           = gnt_q;
    rr_d            = rr_q;
    err_d           = err_q;
    bus.cv_in_valid = 1'b0;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    case (state_q)
      S_PURGE: begin
        cv_ctrl_d = 2'd0;
        if (purge_cnt_q == KW'(PURGE_CYC - 1)) state_d = S_IDLE;
        else                                   purge_cnt_d = purge_cnt_q + KW'(1);
      end
      S_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          gnt_d   = win;
          gmode_d = win_mode;
          if (win_mode == 2'd3) begin
            state_d = S_DROP;
          end else if (win_mode_ok) begin
            cv_ctrl_d = win_mode;
            state_d   = S_STREAM;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0) begin
          cv_ctrl_d = gmode_q;
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        bus.cv_in_valid = sel_vld && gate;
        if (gnt_q) bus.req1_ready = bus.cv_in_ready && gate;
        else       bus.req0_ready = bus.cv_in_ready && gate;
        if (sel_vld && gate && bus.cv_in_ready && sel_last) begin
          state_d = S_IDLE;
          rr_d    = ~gnt_q;
        end
      end
      S_DROP: begin
        if (gnt_q) bus.req1_ready = 1'b1;
        else       bus.req0_ready = 1'b1;
        if (sel_vld) begin
          err_d = 1'b1;
          if (sel_last) begin
            state_d = S_IDLE;
            rr_d    = ~gnt_q;
          end
        end
      end
      default: state_d = S_PURGE;
    endcase
  end

  // Stale converter output during PURGE is swallowed; afterwards results stream to the kernel.
  always_comb begin
    bus.res_valid    = 1'b0;
    bus.cv_out_ready = 1'b1;
    bus.res_data     = bus.cv_out_data;
    bus.res_src      = 1'b0;
    bus.res_last     = 1'b0;
    if (state_q != S_PURGE) begin
      bus.res_valid    = bus.cv_out_valid;
      bus.cv_out_ready = bus.res_ready;
      if (tag_empty) {bus.res_src, bus.res_last} = {gnt_q, sel_last};
      else           {bus.res_src, bus.res_last} = tag_q[rd_ptr_q];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !res_fire)                              inflight_d = inflight_q + CW'(1);
    else if (res_fire && !issue && inflight_q != '0)     inflight_d = inflight_q - CW'(1);
    tag_cnt_d = tag_cnt_q;
    if (tag_push && !tag_pop)      tag_cnt_d = tag_cnt_q + CW'(1);
    else if (tag_pop && !tag_push) tag_cnt_d = tag_cnt_q - CW'(1);
    wr_ptr_d = tag_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = tag_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PURGE;
      purge_cnt_q <= '0;
      cv_ctrl_q   <= 2'd0;
      gmode_q     <= 2'd0;
      gnt_q       <= 1'b0;
      rr_q        <= 1'b0;
      err_q       <= 1'b0;
      inflight_q  <= '0;
      tag_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      purge_cnt_q <= purge_cnt_d;
      cv_ctrl_q   <= cv_ctrl_d;
      gmode_q     <= gmode_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      err_q       <= err_d;
      inflight_q  <= inflight_d;
      tag_cnt_q   <= tag_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (tag_push) tag_q[wr_ptr_q] <= {gnt_q, sel_last};
    end
  end
endmodule

// File: tb/tb_radix_conv_scheduler.sv
// Bench for radix_conv_scheduler: behavioural converter (2-cycle latency, mode-2 passthrough when idle)
// and a result scoreboard filled at requester accept time.
module tb_radix_conv_scheduler;
  localparam int MAXI  = 16;
  localparam int PURGE = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  radix_conv_scheduler_if bus();

  radix_conv_scheduler #(.MAX_INFLIGHT(MAXI), .PURGE_CYC(PURGE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [63:0] dat;
    logic        src;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   outstanding = 0;
  int   purge_fires = 0;
  int   purge_res_vld = 0;
  int   neg_idx = 0;
  int   first_acc_idx = -1;
  int   cv_in_fires = 0;
  int   drop_beats = 0;
  int   ctrl_chg = 0;
  logic [1:0] prev_ctrl;
  logic [1:0] mode0_r = 2'd0;
  logic [1:0] mode1_r = 2'd0;
  bit   rnd_on;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] conv(input logic [1:0] m, input logic [63:0] d);
    logic [63:0] r;
    case (m)
      2'd0: if (d[14:0] == 15'd0) r = {d[15], 63'd0};
            else r = {d[15], 11'(d[14:10]) + 11'd1008, d[9:0], 42'd0};
      2'd1: if (d[30:0] == 31'd0) r = {d[31], 63'd0};
            else r = {d[31], 11'(d[30:23]) + 11'd896, d[22:0], 29'd0};
      default: r = d;
    endcase
    return r;
  endfunction

  // Converter model: not reset, preloaded with three stale results on the first edge.
  int          cyc = 0;
  logic [63:0] rdat [32];
  int          rts  [32];
  logic [4:0]  rh = 5'd0;
  logic [4:0]  rt = 5'd0;
  int          rcnt = 0;
  logic        head_ok, pass, ring_push, ring_pop;

  assign head_ok          = (rcnt != 0) && (cyc >= rts[rh] + 2);
  assign pass             = (bus.cv_ctrl == 2'd2) && (rcnt == 0) && bus.cv_out_ready;
  assign bus.cv_out_valid = head_ok | (pass & bus.cv_in_valid);
  assign bus.cv_out_data  = head_ok ? rdat[rh] : bus.cv_in_data;
  assign bus.cv_in_ready  = (rcnt < 24);
  assign ring_pop         = head_ok & bus.cv_out_ready;
  assign ring_push        = bus.cv_in_valid & bus.cv_in_ready & ~pass;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 3; i++) begin
        rdat[i] <= 64'hDEAD_0000_0000_0000 | 64'(i);
        rts[i]  <= 0;
      end
      rt   <= 5'd3;
      rcnt <= 3;
    end else begin
      if (ring_push) begin
        rdat[rt] <= conv(bus.cv_ctrl, bus.cv_in_data);
        rts[rt]  <= cyc;
        rt       <= rt + 5'd1;
      end
      if (ring_pop) rh <= rh + 5'd1;
      rcnt <= rcnt + (ring_push ? 1 : 0) - (ring_pop ? 1 : 0);
    end
  end

  // Monitor: push on requester accept, then pop/compare on result fire (same-cycle passthrough safe).
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst || neg_idx < PURGE) begin
        if (bus.cv_out_valid && bus.cv_out_ready) purge_fires++;
        if (bus.res_valid) purge_res_vld++;
        prev_ctrl = bus.cv_ctrl;
      end else begin
        if (bus.cv_ctrl !== prev_ctrl) begin
          ctrl_chg++;
          check_val("ctrl_change_pipe_empty", 64'(outstanding), 64'd0);
          prev_ctrl = bus.cv_ctrl;
        end
        if (bus.cv_in_valid && bus.cv_in_ready) cv_in_fires++;
        if (bus.req0_valid && bus.req0_ready) begin
          if (first_acc_idx < 0) first_acc_idx = neg_idx;
          if (mode0_r == 2'd3) drop_beats++;
          else begin
            sb.push_back('{conv(mode0_r, bus.req0_data), 1'b0, bus.req0_last});
            outstanding++;
          end
          if (bus.req0_last) grant_log.push_back(0);
        end
        if (bus.req1_valid && bus.req1_ready) begin
          if (mode1_r == 2'd3) drop_beats++;
          else begin
            sb.push_back('{conv(mode1_r, bus.req1_data), 1'b1, bus.req1_last});
            outstanding++;
          end
          if (bus.req1_last) grant_log.push_back(1);
        end
        if (bus.res_valid && bus.res_ready) begin
          if (sb.size() == 0) check_val("res_unexpected", 64'd1, 64'd0);
          else begin
            exp_t e;
            e = sb.pop_front();
            outstanding--;
            check_val("res_data", bus.res_data, e.dat);
            check_val("res_src", 64'(bus.res_src), 64'(e.src));
            check_val("res_last", 64'(bus.res_last), 64'(e.last));
          end
        end
        if (outstanding > MAXI) check_val("inflight_cap", 64'(outstanding), 64'(MAXI));
      end
      if (rst) neg_idx = 0;
      else     neg_idx++;
    end
  end

  task automatic set_req(input int r, input logic v, input logic [63:0] d, input logic l, input logic [1:0] m);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l; bus.req0_mode = m;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l; bus.req1_mode = m;
    end
  endtask

  task automatic send_burst(input int r, input logic [1:0] mode, input int n,
                            input logic [63:0] d0, input logic [63:0] step);
    if (r == 0) mode0_r = mode;
    else        mode1_r = mode;
    for (int i = 0; i < n; i++) begin
      int  t;
      bit  got;
      t   = 0;
      got = 0;
      set_req(r, 1'b1, d0 + step * 64'(i), (i == n - 1), mode);
      while (!got && t < 400) begin
        @(negedge clk);
        got = (r == 0) ? bus.req0_ready : bus.req1_ready;
        t++;
      end
      check_val($sformatf("accept_r%0d", r), 64'(got), 64'd1);
      @(posedge clk); #1;
      if (!got) break;
    end
    set_req(r, 1'b0, 64'd0, 1'b0, 2'd0);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_val(tag, 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base_chg, base_fires;
    set_req(0, 1'b0, 64'd0, 1'b0, 2'd0);
    set_req(1, 1'b0, 64'd0, 1'b0, 2'd0);
    bus.res_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_cv_ctrl", 64'(bus.cv_ctrl), 64'd0);
    check_val("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check_val("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
    check_val("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
    check_val("rst_cv_in_valid", 64'(bus.cv_in_valid), 64'd0);
    check_val("rst_err_mode", 64'(bus.err_mode), 64'd0);
    check_val("rst_res_src_last", {62'd0, bus.res_src, bus.res_last}, 64'd0);
    @(posedge clk); #1;

    // Half-precision burst straight after reset; first accept comes one IDLE cycle after PURGE.
    send_burst(0, 2'd0, 4, 64'h3C00, 64'd0);
    wait_drain("t2_drain");
    check_val("t1_purge_discards", 64'(purge_fires), 64'd3);
    check_val("t1_purge_res_valid", 64'(purge_res_vld), 64'd0);
    check_val("t1_first_accept_idx", 64'(first_acc_idx), 64'(PURGE + 1));
    check_val("t2_cv_ctrl", 64'(bus.cv_ctrl), 64'd0);

    // Mode switch with a pending requester must wait for an empty converter.
    base_chg = ctrl_chg;
    fork
      send_burst(0, 2'd1, 4, 64'h3F80_0000, 64'h0080_0000);
      begin
        repeat (2) @(posedge clk);
        #1;
        send_burst(1, 2'd0, 3, 64'h3C00, 64'h0400);
      end
    join
    wait_drain("t3_drain");
    check_val("t3_ctrl_changes", 64'(ctrl_chg - base_chg), 64'd2);
    check_val("t3_cv_ctrl", 64'(bus.cv_ctrl), 64'd0);

    // Same-mode contention with a jittery kernel: grants alternate and bursts overlap.
    grant_log.delete();
    base_chg = ctrl_chg;
    rnd_on = 1'b1;
    fork
      begin
        fork
          for (int i = 0; i < 3; i++) send_burst(0, 2'd2, 2, 64'hA000_0000_0000_0000 + 64'(i * 16), 64'd1);
          for (int i = 0; i < 3; i++) send_burst(1, 2'd2, 2, 64'hB000_0000_0000_0000 + 64'(i * 16), 64'd1);
        join
        rnd_on = 1'b0;
      end
      while (rnd_on) begin
        @(posedge clk); #1;
        bus.res_ready = 1'($urandom_range(0, 1));
      end
    join
    bus.res_ready = 1'b1;
    wait_drain("t4_drain");
    check_val("t4_grant_count", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < grant_log.size() && i < 6; i++)
      check_val($sformatf("t4_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));
    check_val("t4_ctrl_changes", 64'(ctrl_chg - base_chg), 64'd1);

    // Credit cap: kernel stalled, 20-beat burst stops at MAXI in flight.
    bus.res_ready = 1'b0;
    fork
      send_burst(0, 2'd1, 20, 64'h3F80_0000, 64'h0001_0000);
      begin
        repeat (60) @(posedge clk);
        @(negedge clk);
        check_val("t5_outstanding", 64'(outstanding), 64'(MAXI));
        check_val("t5_cv_in_valid", 64'(bus.cv_in_valid), 64'd0);
        check_val("t5_req0_ready", 64'(bus.req0_ready), 64'd0);
        check_val("t5_res_valid_blocked", 64'(bus.res_valid & bus.res_ready), 64'd0);
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
      end
    join
    wait_drain("t5_drain");

    // Illegal mode burst is swallowed and flagged; following burst still works.
    check_val("t6_err_before", 64'(bus.err_mode), 64'd0);
    base_fires = cv_in_fires;
    send_burst(1, 2'd3, 3, 64'h1234, 64'd1);
    @(negedge clk);
    check_val("t6_drop_beats", 64'(drop_beats), 64'd3);
    check_val("t6_no_issue", 64'(cv_in_fires - base_fires), 64'd0);
    check_val("t6_err_set", 64'(bus.err_mode), 64'd1);
    @(posedge clk); #1;
    send_burst(0, 2'd0, 2, 64'h3C00, 64'h0400);
    wait_drain("t6_drain");
    check_val("t6_err_sticky", 64'(bus.err_mode), 64'd1);
    check_val("t6_cv_ctrl", 64'(bus.cv_ctrl), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
